// File: rtl/axi_host_initiator.sv
// Single-outstanding AXI4 master: turns host read/write-one-word commands into single-beat bursts.
// Optional response-wait watchdog enabled by defining AXI_HOST_TIMEOUT_EN.
module axi_host_initiator #(
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned AXI_ADDR_WIDTH = 31,
  parameter int unsigned AXI_TID_WIDTH  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_strb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_data,
  output logic                          rsp_err,
  output logic                          timeout,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [AXI_TID_WIDTH-1:0]      m_axi_awid,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic [AXI_TID_WIDTH-1:0]      m_axi_bid,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [AXI_TID_WIDTH-1:0]      m_axi_arid,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic [AXI_TID_WIDTH-1:0]      m_axi_rid,
  input  logic                          m_axi_rlast
);

  localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
  } state_t;

  state_t                      state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]           wstrb_q, wstrb_d;
  logic [AXI_TID_WIDTH-1:0]    id_q, id_d;
  logic [AXI_TID_WIDTH-1:0]    txn_id_q, txn_id_d;
  logic                        aw_done_c, w_done_c;

  // Next-state and next-output logic; every registered output is computed from the transition.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    id_d        = id_q;
    txn_id_d    = txn_id_q;
    aw_done_c   = !awvalid_q || m_axi_awready;
    w_done_c    = !wvalid_q  || m_axi_wready;

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d            = 1'b0;
          addr_d                 = cmd_addr;
          addr_d[ADDR_LSB-1:0]   = '0;
          wdata_d                = cmd_data;
          wstrb_d                = cmd_strb;
          id_d                   = txn_id_q;
          txn_id_d               = AXI_TID_WIDTH'(txn_id_q + 1'b1);
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; B is awaited only once both are accepted.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done_c && w_done_c) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = (m_axi_bresp != 2'b00) || (m_axi_bid != id_q);
          state_d     = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = m_axi_rdata;
          rsp_err_d   = (m_axi_rresp != 2'b00) || (m_axi_rid != id_q) || !m_axi_rlast;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      id_q        <= '0;
      txn_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      id_q        <= id_d;
      txn_id_q    <= txn_id_d;
    end
  end

`ifdef AXI_HOST_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  // Wait counter restarts whenever the FSM is outside a response-wait state; the flag is sticky.
  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q;
    if (state_q == S_WR_RESP || state_q == S_RD_RESP) begin
      to_cnt_d = to_cnt_q;
      if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) to_cnt_d = TO_W'(to_cnt_q + 1'b1);
      if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = id_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(ADDR_LSB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0000;
  assign m_axi_awprot  = 3'b000;

  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = bready_q;

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arid    = id_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(ADDR_LSB);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;

endmodule
